// File: rtl/cam_pkg.sv
// Shared definitions for the RAM-based CAM controller: opcodes, FSM states and
// the one-hot / lowest-index encoder helpers.
package cam_pkg;

  localparam int unsigned MAX_ADDR_WIDTH = 8;
  localparam int unsigned MAX_ENTRIES    = 2 ** MAX_ADDR_WIDTH;

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_FLUSH  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRCH,
    ST_CLR_RD,
    ST_CLR_WR,
    ST_SET_RD,
    ST_SET_WR,
    ST_FLUSH
  } state_t;

  // Sized for the widest supported row; callers cast down to their own width.
  function automatic logic [MAX_ENTRIES-1:0] onehot(input logic [MAX_ADDR_WIDTH-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  function automatic logic [MAX_ADDR_WIDTH-1:0] prio_lowest(input logic [MAX_ENTRIES-1:0] vec);
    prio_lowest = '0;
    for (int i = MAX_ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) prio_lowest = MAX_ADDR_WIDTH'(i);
    end
  endfunction

endpackage

// File: rtl/cam_row_ram.sv
// Row memory of the CAM: one write port, one registered read port, no reset.
module cam_row_ram #(
  parameter int unsigned KEY_WIDTH = 8,
  parameter int unsigned ENTRIES   = 32
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [KEY_WIDTH-1:0] wr_addr,
  input  logic [ENTRIES-1:0]   wr_data,
  input  logic [KEY_WIDTH-1:0] rd_addr,
  output logic [ENTRIES-1:0]   rd_data
);

  logic [ENTRIES-1:0] mem [2 ** KEY_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cam_ram_ctrl.sv
// CAM engine: command handshake, entry valid/key shadow, re-map on write,
// delete, priority-encoded search and an automatic flush after reset.
module cam_ram_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned KEY_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [KEY_WIDTH-1:0]       cmd_key,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  output logic                       res_valid,
  output logic [1:0]                 res_op,
  output logic [2**ADDR_WIDTH-1:0]   res_match,
  output logic                       res_hit,
  output logic [ADDR_WIDTH-1:0]      res_addr
);

  localparam int unsigned ENTRIES = 2 ** ADDR_WIDTH;

  state_t                state;
  logic [KEY_WIDTH:0]    cnt;
  logic [KEY_WIDTH:0]    cnt_nxt;
  logic                  flush_cmd;
  logic [ENTRIES-1:0]    valid;
  logic [KEY_WIDTH-1:0]  shadow [ENTRIES];
  logic [1:0]            op_q;
  logic [KEY_WIDTH-1:0]  key_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  hit_q;
  logic                  accept;
  logic [ENTRIES-1:0]    oh;

  logic                  ram_we;
  logic [KEY_WIDTH-1:0]  ram_wr_addr;
  logic [ENTRIES-1:0]    ram_wr_data;
  logic [KEY_WIDTH-1:0]  ram_rd_addr;
  logic [ENTRIES-1:0]    rd_data;

  assign accept  = cmd_valid && cmd_ready;
  assign cnt_nxt = cnt + (KEY_WIDTH + 1)'(1);
  assign oh      = ENTRIES'(onehot(MAX_ADDR_WIDTH'(addr_q)));

  // Exactly one memory access per state; the search read is launched on accept.
  always_comb begin
    ram_rd_addr = key_q;
    ram_we      = 1'b0;
    ram_wr_addr = key_q;
    ram_wr_data = '0;
    case (state)
      ST_IDLE:   ram_rd_addr = cmd_key;
      ST_CLR_RD: ram_rd_addr = shadow[addr_q];
      ST_CLR_WR: begin
        ram_we      = 1'b1;
        ram_wr_addr = shadow[addr_q];
        ram_wr_data = rd_data & ~oh;
      end
      ST_SET_WR: begin
        ram_we      = 1'b1;
        ram_wr_data = rd_data | oh;
      end
      ST_FLUSH: begin
        ram_we      = 1'b1;
        ram_wr_addr = cnt[KEY_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  cam_row_ram #(
    .KEY_WIDTH(KEY_WIDTH),
    .ENTRIES  (ENTRIES)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .wr_addr(ram_wr_addr),
    .wr_data(ram_wr_data),
    .rd_addr(ram_rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (state == ST_SET_WR) shadow[addr_q] <= key_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FLUSH;
      cnt       <= '0;
      flush_cmd <= 1'b0;
      valid     <= '0;
      cmd_ready <= 1'b0;
      op_q      <= OP_SEARCH;
      key_q     <= '0;
      addr_q    <= '0;
      hit_q     <= 1'b0;
      res_valid <= 1'b0;
      res_op    <= '0;
      res_match <= '0;
      res_hit   <= 1'b0;
      res_addr  <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            key_q     <= cmd_key;
            addr_q    <= cmd_addr;
            hit_q     <= valid[cmd_addr];
            case (cmd_op)
              OP_SEARCH: state <= ST_SRCH;
              OP_WRITE:  state <= (valid[cmd_addr] && shadow[cmd_addr] != cmd_key)
                                  ? ST_CLR_RD : ST_SET_RD;
              OP_DELETE: begin
                if (valid[cmd_addr]) begin
                  state <= ST_CLR_RD;
                end else begin
                  res_valid <= 1'b1;
                  res_op    <= cmd_op;
                  res_match <= '0;
                  res_hit   <= 1'b0;
                  res_addr  <= cmd_addr;
                end
              end
              default: begin
                state     <= ST_FLUSH;
                cnt       <= '0;
                flush_cmd <= 1'b1;
                valid     <= '0;
              end
            endcase
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_SRCH: begin
          res_valid <= 1'b1;
          res_op    <= op_q;
          res_match <= rd_data;
          res_hit   <= |rd_data;
          res_addr  <= ADDR_WIDTH'(prio_lowest(MAX_ENTRIES'(rd_data)));
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        ST_CLR_RD: begin
          if (op_q == OP_DELETE) begin
            res_valid <= 1'b1;
            res_op    <= op_q;
            res_match <= '0;
            res_hit   <= hit_q;
            res_addr  <= addr_q;
          end
          state <= ST_CLR_WR;
        end
        ST_CLR_WR: begin
          if (op_q == OP_WRITE) begin
            state <= ST_SET_RD;
          end else begin
            valid[addr_q] <= 1'b0;
            state         <= ST_IDLE;
            cmd_ready     <= 1'b1;
          end
        end
        ST_SET_RD: begin
          res_valid <= 1'b1;
          res_op    <= op_q;
          res_match <= '0;
          res_hit   <= hit_q;
          res_addr  <= addr_q;
          state     <= ST_SET_WR;
        end
        ST_SET_WR: begin
          valid[addr_q] <= 1'b1;
          state         <= ST_IDLE;
          cmd_ready     <= 1'b1;
        end
        ST_FLUSH: begin
          cnt <= cnt_nxt;
          // Wide counter: terminal count shows up as the carry bit.
          if (cnt_nxt[KEY_WIDTH]) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            flush_cmd <= 1'b0;
            if (flush_cmd) begin
              res_valid <= 1'b1;
              res_op    <= OP_FLUSH;
              res_match <= '0;
              res_hit   <= 1'b0;
              res_addr  <= addr_q;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_ram_ctrl.sv
// Directed bench for cam_ram_ctrl with an expected-result queue checked
// whenever the controller reports a completed command.
module tb_cam_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_key = 8'h00;
  logic [4:0]  cmd_addr = 5'd0;
  logic        res_valid;
  logic [1:0]  res_op;
  logic [31:0] res_match;
  logic        res_hit;
  logic [4:0]  res_addr;

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] match;
    logic        hit;
    logic [4:0]  addr;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nid = 0;
  int   vectors = 0;
  int   miscompares = 0;

  cam_ram_ctrl #(.KEY_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_key  (cmd_key),
    .cmd_addr (cmd_addr),
    .res_valid(res_valid),
    .res_op   (res_op),
    .res_match(res_match),
    .res_hit  (res_hit),
    .res_addr (res_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Result monitor, sampled well after the active edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rst_n && res_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_res_valid", 64'(res_valid), 64'(0));
      end else begin
        e = q.pop_front();
        chk($sformatf("res_op#%0d", e.id),    64'(res_op),    64'(e.op));
        chk($sformatf("res_match#%0d", e.id), 64'(res_match), 64'(e.match));
        chk($sformatf("res_hit#%0d", e.id),   64'(res_hit),   64'(e.hit));
        chk($sformatf("res_addr#%0d", e.id),  64'(res_addr),  64'(e.addr));
        chk($sformatf("latency#%0d", e.id),   64'(cyc),       64'(e.cyc));
      end
    end
  end

  // Drive one command; lat = accept edge to first edge sampling res_valid high.
  task automatic issue(input logic [1:0] op, input logic [7:0] key, input logic [4:0] addr,
                       input bit want, input logic [31:0] m, input logic h,
                       input logic [4:0] ra, input int lat);
    int n = 0;
    cmd_op    = op;
    cmd_key   = key;
    cmd_addr  = addr;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("cmd_ready_wait#%0d", nid), 64'(cmd_ready), 64'(1));
    if (want) q.push_back('{id: nid, op: op, match: m, hit: h, addr: ra, cyc: cyc + lat});
    nid++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic init_flush_len(input string tag);
    int n = 0;
    while (!cmd_ready && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, 64'(n), 64'(256));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    #2;
    chk("drain_queue", 64'(q.size()), 64'(0));
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    chk({tag, "_res_op"},    64'(res_op),    64'(0));
    chk({tag, "_res_match"}, 64'(res_match), 64'(0));
    chk({tag, "_res_hit"},   64'(res_hit),   64'(0));
    chk({tag, "_res_addr"},  64'(res_addr),  64'(0));
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_outputs("por");
    rst_n = 1'b1;
    init_flush_len("init_flush_cycles");

    issue(2'b00, 8'h00, 5'd0,  1, 32'h0000_0000, 1'b0, 5'd0, 2);
    issue(2'b01, 8'h3C, 5'd5,  1, 32'h0,         1'b0, 5'd5, 2);
    issue(2'b01, 8'h3C, 5'd9,  1, 32'h0,         1'b0, 5'd9, 2);
    issue(2'b00, 8'h3C, 5'd0,  1, 32'h0000_0220, 1'b1, 5'd5, 2);
    issue(2'b01, 8'h7E, 5'd5,  1, 32'h0,         1'b1, 5'd5, 4);
    issue(2'b00, 8'h3C, 5'd0,  1, 32'h0000_0200, 1'b1, 5'd9, 2);
    issue(2'b00, 8'h7E, 5'd0,  1, 32'h0000_0020, 1'b1, 5'd5, 2);
    issue(2'b01, 8'h7E, 5'd5,  1, 32'h0,         1'b1, 5'd5, 2);
    issue(2'b00, 8'h7E, 5'd0,  1, 32'h0000_0020, 1'b1, 5'd5, 2);
    issue(2'b10, 8'h00, 5'd9,  1, 32'h0,         1'b1, 5'd9, 2);
    issue(2'b00, 8'h3C, 5'd0,  1, 32'h0000_0000, 1'b0, 5'd0, 2);
    issue(2'b10, 8'h00, 5'd9,  1, 32'h0,         1'b0, 5'd9, 1);
    issue(2'b01, 8'hFF, 5'd31, 1, 32'h0,         1'b0, 5'd31, 2);
    issue(2'b01, 8'h00, 5'd0,  1, 32'h0,         1'b0, 5'd0, 2);
    issue(2'b00, 8'hFF, 5'd0,  1, 32'h8000_0000, 1'b1, 5'd31, 2);
    issue(2'b00, 8'h00, 5'd0,  1, 32'h0000_0001, 1'b1, 5'd0, 2);

    issue(2'b11, 8'h00, 5'd7,  1, 32'h0,         1'b0, 5'd7, 257);
    foreach (q[i]) begin end
    issue(2'b00, 8'h7E, 5'd0,  1, 32'h0, 1'b0, 5'd0, 2);
    issue(2'b00, 8'hFF, 5'd0,  1, 32'h0, 1'b0, 5'd0, 2);
    issue(2'b00, 8'h00, 5'd0,  1, 32'h0, 1'b0, 5'd0, 2);
    issue(2'b00, 8'h3C, 5'd0,  1, 32'h0, 1'b0, 5'd0, 2);
    issue(2'b10, 8'h00, 5'd5,  1, 32'h0, 1'b0, 5'd5, 1);

    // Reset while a re-mapping write is in its row write-back state.
    issue(2'b01, 8'h22, 5'd3,  1, 32'h0, 1'b0, 5'd3, 2);
    drain();
    issue(2'b01, 8'h11, 5'd3,  0, 32'h0, 1'b0, 5'd3, 4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    reset_outputs("midop");
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_flush_len("reflush_cycles");
    issue(2'b00, 8'h11, 5'd0,  1, 32'h0, 1'b0, 5'd0, 2);
    issue(2'b00, 8'h22, 5'd0,  1, 32'h0, 1'b0, 5'd0, 2);
    issue(2'b10, 8'h00, 5'd3,  1, 32'h0, 1'b0, 5'd3, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
